// File: rtl/wcrc_pkg.sv
// rtl/wcrc_pkg.sv - shared CRC definitions for the packer and the stage-2 checker
//
// Purpose: CRC width, chunk width, generator polynomial, init value, the
// packer FSM state type, and crc_step(), which folds one D-bit chunk into the
// CRC MSB-first. The checker recomputes with the same function, so both sides
// agree bit-exactly.
package wcrc_pkg;

  localparam int                 WCRC_CL   = 8;
  localparam int                 WCRC_D    = 8;
  localparam logic [WCRC_CL-1:0] WCRC_POLY = 8'h07;  // x^8 + x^2 + x + 1
  localparam logic [WCRC_CL-1:0] WCRC_INIT = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FULL = 2'd2
  } pack_state_e;

  // D serial LFSR steps unrolled; chunk[D-1] is consumed first.
  function automatic logic [WCRC_CL-1:0] crc_step(input logic [WCRC_CL-1:0] crc,
                                                  input logic [WCRC_D-1:0]  chunk);
    logic [WCRC_CL-1:0] c;
    logic               fb;
    c = crc;
    for (int i = WCRC_D - 1; i >= 0; i--) begin
      fb = c[WCRC_CL-1] ^ chunk[i];
      c  = {c[WCRC_CL-2:0], 1'b0} ^ (fb ? WCRC_POLY : '0);
    end
    return c;
  endfunction

endpackage

// File: rtl/wcrc_serial_engine.sv
// rtl/wcrc_serial_engine.sv - serial CRC engine, D bits per cycle over an n-bit word
//
// Purpose: load captures a word and clears the CRC; each step folds the next
// D MSBs into the CRC. last_o marks the step that consumes the final chunk,
// and crc_next_o is the CRC that step produces, so the caller can store the
// finished CRC on that same edge.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   load_i      capture data_i, CRC <= init, step counter <= 0
//   data_i      word to protect
//   step_i      fold the next chunk this edge
//   data_o      word captured by the last load
//   crc_next_o  CRC after folding the current chunk
//   last_o      current step consumes the final chunk
module wcrc_serial_engine
  import wcrc_pkg::*;
#(
  parameter int n = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [n-1:0]       data_i,
  input  logic               step_i,
  output logic [n-1:0]       data_o,
  output logic [WCRC_CL-1:0] crc_next_o,
  output logic               last_o
);

  localparam int STEPS = n / WCRC_D;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [n-1:0]       shift_q;
  logic [n-1:0]       data_q;
  logic [WCRC_CL-1:0] crc_q;
  logic [CW-1:0]      cnt_q;

  assign data_o     = data_q;
  assign last_o     = (cnt_q == CW'(STEPS - 1));
  assign crc_next_o = crc_step(crc_q, shift_q[n-1 -: WCRC_D]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      data_q  <= '0;
      crc_q   <= WCRC_INIT;
      cnt_q   <= '0;
    end else if (load_i) begin
      shift_q <= data_i;
      data_q  <= data_i;
      crc_q   <= WCRC_INIT;
      cnt_q   <= '0;
    end else if (step_i) begin
      crc_q   <= crc_next_o;
      shift_q <= shift_q << WCRC_D;
      cnt_q   <= last_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/tmr_wcrc_packer.sv
// rtl/tmr_wcrc_packer.sv - packs N CRC-protected weights into the Wcrc bus
//
// Purpose: accepts one n-bit weight per handshake, runs it through the serial
// CRC engine (n/D cycles), stores {data, crc} into the next lane and raises
// wcrc_valid_o once all N lanes are filled, holding it until wcrc_ack_i.
// err_inj_i flips CRC bit 0 of a lane as it is stored, for fault-path tests.
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   clear_i       synchronous abort: drop partial pack, back to IDLE
//   w_in_i        weight data
//   w_valid_i     w_in_i valid
//   w_ready_o     block accepts w_in_i (IDLE)
//   err_inj_i     per-lane CRC bit 0 inversion, sampled on the lane-write edge
//   wcrc_o        lane j (1..N) at [(n+cl)*j-1 -: n+cl] = {data, crc}
//   wcrc_valid_o  all N lanes packed
//   wcrc_ack_i    consumer has taken wcrc_o (acted on only when full)
//   lane_cnt_o    lanes filled so far
//   busy_o        not IDLE
module tmr_wcrc_packer
  import wcrc_pkg::*;
#(
  parameter int N = 8,
  parameter int n = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic [n-1:0]                w_in_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [N-1:0]                err_inj_i,
  output logic [N*(n+WCRC_CL)-1:0]    wcrc_o,
  output logic                        wcrc_valid_o,
  input  logic                        wcrc_ack_i,
  output logic [$clog2(N+1)-1:0]      lane_cnt_o,
  output logic                        busy_o
);

  localparam int LW   = n + WCRC_CL;
  localparam int LCW  = $clog2(N + 1);
  localparam int LIDX = (N > 1) ? $clog2(N) : 1;

  pack_state_e        state_q;
  logic [LCW-1:0]     lane_cnt_q;
  logic               wcrc_valid_q;
  logic [LW-1:0]      lanes_q [N];

  logic               eng_load;
  logic               eng_step;
  logic [n-1:0]       eng_data;
  logic [WCRC_CL-1:0] eng_crc_next;
  logic               eng_last;
  logic [LIDX-1:0]    lane_idx;

  assign w_ready_o    = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign wcrc_valid_o = wcrc_valid_q;
  assign lane_cnt_o   = lane_cnt_q;

  // In CALC lane_cnt_q never exceeds N-1, so its low bits address the lane.
  assign lane_idx = lane_cnt_q[LIDX-1:0];

  // clear wins over a simultaneous handshake or step.
  assign eng_load = (state_q == ST_IDLE) && w_valid_i && !clear_i;
  assign eng_step = (state_q == ST_CALC) && !clear_i;

  wcrc_serial_engine #(
    .n (n)
  ) u_engine (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (eng_load),
    .data_i     (w_in_i),
    .step_i     (eng_step),
    .data_o     (eng_data),
    .crc_next_o (eng_crc_next),
    .last_o     (eng_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      lane_cnt_q   <= '0;
      wcrc_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        lanes_q[i] <= '0;
      end
    end else if (clear_i) begin
      // Lane contents are left alone; consumers qualify with wcrc_valid.
      state_q      <= ST_IDLE;
      lane_cnt_q   <= '0;
      wcrc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_valid_i) begin
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (eng_last) begin
            lanes_q[lane_idx] <= {eng_data,
                                  eng_crc_next ^ {{(WCRC_CL-1){1'b0}}, err_inj_i[lane_idx]}};
            lane_cnt_q <= lane_cnt_q + LCW'(1);
            if (lane_cnt_q == LCW'(N - 1)) begin
              state_q      <= ST_FULL;
              wcrc_valid_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_FULL: begin
          if (wcrc_ack_i) begin
            state_q      <= ST_IDLE;
            lane_cnt_q   <= '0;
            wcrc_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_pack
    assign wcrc_o[LW*j +: LW] = lanes_q[j];
  end

endmodule
